// File: rtl/microcode_sequencer.sv
// Instruction sequencer for the 8-bit bus CPU: walks T-states and decodes the opcode into the 15-bit control word.
// Latency: control_word, instr_done and halted are combinational from the current T-state, opcode and flags; state advances one step per clock.
// Backpressure: hold aborts to IDLE on the next edge. In IDLE, run or a one-cycle step starts an instruction. HALT can only be left through reset.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   opcode[3:0]     IR opcode, decoded from T3 onward
//   cf, zf          ALU carry / zero flags, sampled combinationally in T3
//   run, step, hold run level, single-instruction pulse, abort-to-IDLE strap
//   control_word    {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
//   t_state         0-5 while executing, 7 in IDLE and HALT
//   instr_done      high during the final T-state of each instruction
//   halted          high in HALT
module microcode_sequencer #(
   parameter logic [14:0] IDLE_WORD = 15'h0FE3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  opcode,
   input  logic        cf,
   input  logic        zf,
   input  logic        run,
   input  logic        step,
   input  logic        hold,
   output logic [14:0] control_word,
   output logic [2:0]  t_state,
   output logic        instr_done,
   output logic        halted
);

   // Bit positions within the control word.
   localparam int B_CP   = 14;
   localparam int B_EP   = 13;
   localparam int B_LP   = 12;
   localparam int B_NLMA = 11;
   localparam int B_NLMD = 10;
   localparam int B_NCE  = 9;
   localparam int B_NLR  = 8;
   localparam int B_NLI  = 7;
   localparam int B_NEI  = 6;
   localparam int B_NLA  = 5;
   localparam int B_EA   = 4;
   localparam int B_SUB  = 3;
   localparam int B_EU   = 2;
   localparam int B_NLB  = 1;
   localparam int B_NLO  = 0;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // T0-T5 are encoded as their own T-state numbers, so t_state can be taken straight from the state register.
   typedef enum logic [2:0] {
      S_T0   = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_HALT = 3'd6,
      S_IDLE = 3'd7
   } state_t;

   state_t      state;
   logic [14:0] word;
   logic        last;

   // Decode. word starts as IDLE_WORD; each step only flips the bits it asserts.
   // last marks the final step of the current opcode. Any unlisted step is treated as final,
   // so an opcode that changes mid-instruction cannot strand the sequencer.
   always_comb begin
      word = IDLE_WORD;
      last = 1'b0;
      case (state)
         S_T0: begin
            word[B_EP]   = 1'b1;
            word[B_NLMA] = 1'b0;
         end
         S_T1: word[B_CP] = 1'b1;
         S_T2: begin
            word[B_NCE] = 1'b0;
            word[B_NLI] = 1'b0;
         end
         S_T3: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  word[B_NEI]  = 1'b0;
                  word[B_NLMA] = 1'b0;
               end
               OP_LDI: begin
                  word[B_NEI] = 1'b0;
                  word[B_NLA] = 1'b0;
                  last        = 1'b1;
               end
               OP_JMP, OP_JC, OP_JZ: begin
                  // A failed conditional jump leaves the idle word but still ends here.
                  if (opcode == OP_JMP || (opcode == OP_JC && cf) || (opcode == OP_JZ && zf)) begin
                     word[B_NEI] = 1'b0;
                     word[B_LP]  = 1'b1;
                  end
                  last = 1'b1;
               end
               OP_OUT: begin
                  word[B_EA]  = 1'b1;
                  word[B_NLO] = 1'b0;
                  last        = 1'b1;
               end
               default: last = 1'b1;   // NOP, 9-D and HLT: idle T3
            endcase
         end
         S_T4: begin
            case (opcode)
               OP_LDA: begin
                  word[B_NCE] = 1'b0;
                  word[B_NLA] = 1'b0;
                  last        = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  word[B_NCE] = 1'b0;
                  word[B_NLB] = 1'b0;
               end
               OP_STA: begin
                  word[B_EA]   = 1'b1;
                  word[B_NLMD] = 1'b0;
               end
               default: last = 1'b1;
            endcase
         end
         S_T5: begin
            case (opcode)
               OP_ADD, OP_SUB: begin
                  word[B_EU]  = 1'b1;
                  word[B_NLA] = 1'b0;
                  word[B_SUB] = (opcode == OP_SUB);
               end
               OP_STA:  word[B_NLR] = 1'b0;
               default: word = IDLE_WORD;
            endcase
            last = 1'b1;
         end
         default: word = IDLE_WORD;   // IDLE, HALT
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_HALT: state <= S_HALT;
            S_IDLE: begin
               if (!hold && (run || step))
                  state <= S_T0;
            end
            default: begin
               if (hold)
                  state <= S_IDLE;
               else if (last) begin
                  if (state == S_T3 && opcode == OP_HLT)
                     state <= S_HALT;
                  else
                     state <= run ? S_T0 : S_IDLE;
               end else
                  state <= state_t'(state + 3'd1);
            end
         endcase
      end
   end

   assign control_word = word;
   assign t_state      = (state == S_HALT) ? 3'd7 : state;
   assign instr_done   = last;
   assign halted       = (state == S_HALT);

endmodule
